// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small byte FIFO, back-to-back 8N1 frames.
// Define UART_TX_PARITY_EN for 8E1 framing with an even parity bit.
module uart_tx_fifo #(
  parameter int CLK_HZ = 25000000,
  parameter int BAUD   = 115200,
  parameter int DIV    = (CLK_HZ + BAUD / 2) / BAUD,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic                     txd,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] DIV_M1 = 16'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shf_q, shf_d;
  logic          txd_q, txd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [DEPTH];

  logic push;
  logic pop;
  logic done;
  logic nonempty;

  assign tx_ready   = (count_q != CW'(DEPTH));
  assign push       = tx_valid & tx_ready;
  assign nonempty   = (count_q != '0);
  assign done       = (cnt_q == '0);
  assign txd        = txd_q;
  assign busy       = (state_q != S_IDLE) | nonempty;
  assign fifo_count = count_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = done ? cnt_q : cnt_q - 16'd1;
    bit_d   = bit_q;
    shf_d   = shf_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (nonempty) begin
          pop     = 1'b1;
          shf_d   = mem_q[rd_q];
          state_d = S_START;
          cnt_d   = DIV_M1;
          txd_d   = 1'b0;
        end
      end
      S_START: begin
        if (done) begin
          state_d = S_DATA;
          cnt_d   = DIV_M1;
          bit_d   = 3'd0;
          txd_d   = shf_q[0];
        end
      end
      S_DATA: begin
        if (done) begin
          cnt_d = DIV_M1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            txd_d   = ^shf_q;
`else
            state_d = S_STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            txd_d = shf_q[bit_q + 3'd1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (done) begin
          state_d = S_STOP;
          cnt_d   = DIV_M1;
          txd_d   = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (done) begin
          // Chain straight into the next start bit when data is waiting
          if (nonempty) begin
            pop     = 1'b1;
            shf_d   = mem_q[rd_q];
            state_d = S_START;
            cnt_d   = DIV_M1;
            txd_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_comb begin
    wr_d    = push ? wr_q + 1'b1 : wr_q;
    rd_d    = pop ? rd_q + 1'b1 : rd_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shf_q   <= '0;
      txd_q   <= 1'b1;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shf_q   <= shf_d;
      txd_q   <= txd_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= tx_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: line-level reference model plus scenario tasks.
// Define UART_TX_PARITY_EN to run the 8E1 variant.
module tb_uart_tx_fifo;

  localparam int DIV   = 217;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int F = NB * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       txd;
  logic       busy;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #20 clk = ~clk;

  uart_tx_fifo dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .txd        (txd),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: queue of pending bytes and cycles left in the current frame
  logic [7:0] mq[$];
  int         mrem = 0;
  logic [7:0] mcur = 8'h00;
  bit         m_pop, m_push;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      mrem = 0;
    end else begin
      m_pop  = (mq.size() != 0) && (mrem <= 1);
      m_push = tx_valid && (mq.size() != DEPTH);
      if (m_pop) begin
        mcur = mq.pop_front();
        mrem = F;
      end else if (mrem > 0) begin
        mrem = mrem - 1;
      end
      if (m_push) mq.push_back(tx_data);
    end
  end

  function automatic logic exp_txd();
    int k;
    if (mrem == 0) return 1'b1;
    k = (F - mrem) / DIV;
    if (k == 0) return 1'b0;
    if (k <= 8) return mcur[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^mcur;
`endif
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      checks = checks + 4;
      if (txd !== exp_txd()) begin
        errors++;
        $display("FAIL line txd=%b expected=%b t=%0t", txd, exp_txd(), $time);
      end
      if (busy !== ((mrem != 0) || (mq.size() != 0))) begin
        errors++;
        $display("FAIL busy got=%b t=%0t", busy, $time);
      end
      if (fifo_count !== 3'(mq.size())) begin
        errors++;
        $display("FAIL count got=%0d expected=%0d t=%0t", fifo_count, mq.size(), $time);
      end
      if (tx_ready !== (mq.size() != DEPTH)) begin
        errors++;
        $display("FAIL ready got=%b t=%0t", tx_ready, $time);
      end
    end
  end

  task automatic push_hold(input logic [7:0] b);
    int g;
    g = 0;
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    while (mq.size() == DEPTH && g < 3 * F) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (g >= 3 * F) begin
      errors++;
      $display("FAIL push_timeout got=%0d limit=%0d", g, 3 * F);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    @(negedge clk);
    tx_valid = 1'b0;
    while ((mrem != 0 || mq.size() != 0) && g < 8 * F) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (busy !== 1'b0 || g >= 8 * F) begin
      errors++;
      $display("FAIL drain busy=%b cycles=%0d required busy=0", busy, g);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #200;
    checks++;
    if ({txd, busy, tx_ready, fifo_count} !== 6'b101_000) begin
      errors++;
      $display("FAIL reset_hold got=%b required=101000", {txd, busy, tx_ready, fifo_count});
    end
    reset = 1'b0;
    repeat (250) begin
      @(negedge clk);
      checks++;
      if ({txd, busy, tx_ready, fifo_count} !== 6'b101_000) begin
        errors++;
        $display("FAIL reset_idle got=%b required=101000", {txd, busy, tx_ready, fifo_count});
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] b;
    logic       e;
    int         t;
    b = 8'h55;
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (txd !== 1'b1 || fifo_count !== 3'd1) begin
      errors++;
      $display("FAIL single_write txd=%b count=%0d required 1/1", txd, fifo_count);
    end
    @(negedge clk);
    tx_valid = 1'b0;
    @(posedge clk);
    #1;
    t = 0;
    checks++;
    if (txd !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL single_start txd=%b count=%0d required 0/0", txd, fifo_count);
    end
    for (int i = 0; i < NB; i++) begin
      repeat (i * DIV + 108 - t) @(posedge clk);
      #1;
      t = i * DIV + 108;
      if (i == 0) e = 1'b0;
      else if (i <= 8) e = b[i-1];
      else if (i == NB - 1) e = 1'b1;
      else e = ^b;
      checks++;
      if (txd !== e) begin
        errors++;
        $display("FAIL single_bit%0d got=%b required=%b", i, txd, e);
      end
    end
    repeat (F - 1 - t) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy_end got=%b required=1", busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || txd !== 1'b1) begin
      errors++;
      $display("FAIL single_done busy=%b txd=%b required 0/1", busy, txd);
    end
  endtask

  task automatic test_burst();
    logic [7:0] bytes [5];
    int t0;
    int g;
    bytes = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81};
    push_hold(bytes[0]);
    t0 = cyc;
    for (int i = 1; i < 5; i++) push_hold(bytes[i]);
    @(negedge clk);
    tx_valid = 1'b0;
    g = 0;
    while (busy !== 1'b0 && g < 6 * F) begin
      @(posedge clk);
      #1;
      g++;
    end
    checks++;
    if (cyc - t0 !== 1 + 5 * F) begin
      errors++;
      $display("FAIL burst_span got=%0d required=%0d", cyc - t0, 1 + 5 * F);
    end
  endtask

  task automatic test_back_to_back();
    int g;
    push_hold(8'h11);
    push_hold(8'h22);
    push_hold(8'h33);
    push_hold(8'h44);
    @(negedge clk);
    tx_valid = 1'b0;
    g = 0;
    while (mrem != 1 && g < 2 * F) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (fifo_count !== 3'd3) begin
      errors++;
      $display("FAIL simul_pre count=%0d required=3", fifo_count);
    end
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (fifo_count !== 3'd3) begin
      errors++;
      $display("FAIL simul_pushpop count=%0d required=3", fifo_count);
    end
    @(negedge clk);
    tx_data = 8'h66;
    @(posedge clk);
    #1;
    checks++;
    if (fifo_count !== 3'd4 || tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL full count=%0d ready=%b required 4/0", fifo_count, tx_ready);
    end
    @(negedge clk);
    tx_data = 8'h77;
    g = 0;
    while (mrem != 1 && g < 2 * F) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (fifo_count !== 3'd3 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_pop count=%0d ready=%b required 3/1", fifo_count, tx_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (fifo_count !== 3'd4) begin
      errors++;
      $display("FAIL held_write count=%0d required=4", fifo_count);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    int g;
    b = 8'hC3;
    push_hold(b);
    push_hold(8'h99);
    @(negedge clk);
    tx_valid = 1'b0;
    g = 0;
    while (mrem != F - (4 * DIV + 100) && g < 2 * F) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (txd !== b[3]) begin
      errors++;
      $display("FAIL mid_bit3 got=%b required=%b", txd, b[3]);
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({txd, busy, tx_ready, fifo_count} !== 6'b101_000) begin
      errors++;
      $display("FAIL mid_reset got=%b required=101000", {txd, busy, tx_ready, fifo_count});
    end
    #100;
    @(negedge clk);
    reset = 1'b0;
    push_hold(8'h12);
    drain();
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int t0;
    int g;
    push_hold(8'h07);
    t0 = cyc;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (9 * DIV + 108) @(posedge clk);
    #1;
    checks++;
    if (txd !== 1'b1) begin
      errors++;
      $display("FAIL parity_bit got=%b required=1", txd);
    end
    g = 0;
    while (busy !== 1'b0 && g < 2 * F) begin
      @(posedge clk);
      #1;
      g++;
    end
    checks++;
    if (cyc - t0 !== 1 + 2387) begin
      errors++;
      $display("FAIL parity_frame got=%0d required=%0d", cyc - t0 - 1, 2387);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        tx_valid = 1'b0;
        repeat ($urandom_range(1, 3000)) @(negedge clk);
      end
      push_hold(8'($urandom));
    end
    drain();
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog time=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_back_to_back();
    test_reset_mid();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
